// File: rtl/bss_serial_subtractor.sv
// Borrow-skip serial subtractor: diff = a - b - bin, one GROUP-bit slice resolved per clock.
// Optional signed-overflow output enabled by defining BSS_SUB_OVF_EN.
module bss_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              bin,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  diff,
  output logic                              bout,
`ifdef BSS_SUB_OVF_EN
  output logic                              ovf,
`endif
  output logic [$clog2(WIDTH/GROUP+1)-1:0]  skip_cnt
);

  localparam int NG = WIDTH / GROUP;
  localparam int KW = (NG > 1) ? $clog2(NG) : 1;
  localparam int SW = $clog2(NG + 1);

  generate
    if ((WIDTH % GROUP) != 0) begin : g_bad_cfg
      $error("bss_serial_subtractor: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             borrow_q;
  logic [KW-1:0]    k_q;
  logic [SW-1:0]    skip_q;
  logic             last_grp;

  logic [GROUP-1:0] ga, gb, gd;
  logic             rip, g_prop, g_bout;

  assign last_grp = (k_q == KW'(NG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_BUSY;
      S_BUSY:  if (last_grp)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Ripple the current slice; a fully-propagating slice forwards its borrow-in unchanged.
  always_comb begin
    ga  = a_q[k_q*GROUP +: GROUP];
    gb  = b_q[k_q*GROUP +: GROUP];
    gd  = '0;
    rip = borrow_q;
    for (int i = 0; i < GROUP; i++) begin
      gd[i] = ga[i] ^ gb[i] ^ rip;
      rip   = (~ga[i] & gb[i]) | (~(ga[i] ^ gb[i]) & rip);
    end
    g_prop = &(~(ga ^ gb));
    g_bout = g_prop ? borrow_q : rip;
  end

`ifdef BSS_SUB_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      skip_q   <= '0;
`ifdef BSS_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            k_q      <= '0;
            skip_q   <= '0;
            diff_q   <= '0;
`ifdef BSS_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        S_BUSY: begin
          diff_q[k_q*GROUP +: GROUP] <= gd;
          borrow_q                   <= g_bout;
          skip_q                     <= skip_q + SW'(g_prop);
          if (!last_grp) k_q <= k_q + 1'b1;
`ifdef BSS_SUB_OVF_EN
          // Last slice holds the sign bit, so its fresh MSB is the result sign.
          if (last_grp)
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (gd[GROUP-1] != a_q[WIDTH-1]);
`endif
        end
        default: ;
      endcase
    end
  end

  assign diff     = diff_q;
  assign bout     = borrow_q;
  assign skip_cnt = skip_q;
`ifdef BSS_SUB_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_bss_serial_subtractor.sv
// Scoreboard bench for bss_serial_subtractor: directed boundary cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_bss_serial_subtractor;

  localparam int W  = 32;
  localparam int NG = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          bin_i = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  diff;
  logic          bout;
  logic [3:0]    skip_cnt;
`ifdef BSS_SUB_OVF_EN
  logic          ovf;
`endif

  always #5 clk = ~clk;

  bss_serial_subtractor #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .bin       (bin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef BSS_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .skip_cnt  (skip_cnt)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           sk;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
    exp_t        m;
    logic [W:0]  r;
    r    = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbi);
    m.d  = r[W-1:0];
    m.bo = r[W];
    m.sk = 0;
    for (int g = 0; g < NG; g++)
      if (ma[g*4 +: 4] == mb[g*4 +: 4]) m.sk++;
    m.ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    return m;
  endfunction

  // Monitor: a result is consumed on the edge after a negedge that shows valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("diff", diff, mon_e.d);
        check("bout", bout, mon_e.bo);
        check("skip_cnt", skip_cnt, mon_e.sk);
`ifdef BSS_SUB_OVF_EN
        check("ovf", ovf, mon_e.ov);
`endif
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                       input int stall, output bit ok);
    int guard;
    ok = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    a_i = ta; b_i = tb; bin_i = tbi;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(model(ta, tb, tbi));
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("busy_in_ready", in_ready, 0);
    ok = 1'b1;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                       input int stall);
    int           lat;
    bit           ok;
    logic [W-1:0] hold_d;
    logic         hold_b;
    issue(ta, tb, tbi, stall, ok);
    if (!ok) return;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check("latency", lat, NG);
    for (int i = 0; i < stall; i++) begin
      hold_d = diff;
      hold_b = bout;
      @(posedge clk);
      #1 in_valid = 1'b1;
      a_i = $urandom; b_i = $urandom; bin_i = 1'b1;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_diff", diff, hold_d);
      check("hold_bout", bout, hold_b);
      check("hold_in_ready", in_ready, 0);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           ok;
    int           guard;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_skip", skip_cnt, 0);
    #20 rst_n = 1'b1;

    do_op(32'd5, 32'd3, 1'b0, 0);
    do_op(32'd0, 32'd1, 1'b0, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    do_op(32'h0, 32'h0, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    do_op(32'hF0F0_0000, 32'h0F0F_0000, 1'b0, 5);

    // Abort an operation mid-flight, then confirm no residue leaks into the next one.
    issue(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 0, ok);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_skip", skip_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(32'd10, 32'd4, 1'b0, 0);

`ifdef BSS_SUB_OVF_EN
    do_op(32'h8000_0000, 32'h1, 1'b0, 0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
`endif

    for (int n = 0; n < 1500; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ ({$urandom} & 32'h0F0F_F00F);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
